// File: rtl/knight_pkg.sv
// Shared types and constants for the Knight's Tour command sequencer.
//   seq_state_t : sequencer FSM states
//   err_code_t  : error codes reported on err_code
//   RESP_POS_ACK, CMD_CAL and the heading bytes used to build move commands
package knight_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_DONE,
    S_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SENT_TMO = 2'd1,
    ERR_RESP_TMO = 2'd2,
    ERR_MISMATCH = 2'd3
  } err_code_t;

  localparam logic [7:0]  RESP_POS_ACK = 8'hA5;
  localparam logic [15:0] CMD_CAL      = 16'h0000;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command buffer with wrap-around pointers and an occupancy count.
//   clk, rst_n       : clock, async active-low reset
//   i_push / i_data  : write one entry (dropped when full)
//   i_pop / o_data   : o_data is the head; i_pop advances it (ignored when empty)
//   i_flush          : empty the buffer; wins over push and pop
//   o_full, o_empty, o_count : occupancy status
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && !i_flush && (r_count != FULL_CNT);
  assign w_pop_ok  = i_pop  && !i_flush && (r_count != '0);

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/knight_cmd_sequencer.sv
// Command sequencer driving the RemoteComm command interface.
// Buffers commands tagged with an expected response byte and response count,
// issues them in order, waits for cmd_sent and each resp_rdy with a timeout,
// and checks every response byte.
//   clk, rst_n                         : clock, async active-low reset
//   wr_en, wr_cmd, wr_exp, wr_nresp    : script entry push
//   start, abort                       : run / stop-and-flush
//   send_cmd, cmd, cmd_sent, resp_rdy, resp : RemoteComm handshake
//   full, empty, busy, done, err, err_code, err_idx, pass_cnt : status
//
// state       | meaning
// S_IDLE      | waiting for start
// S_ISSUE     | send_cmd high for one cycle, head entry already latched
// S_WAIT_SENT | waiting for cmd_sent
// S_WAIT_RESP | waiting for the remaining responses
// S_DONE      | script finished cleanly, done held
// S_ERR       | failure recorded, remaining entries kept for resume
module knight_cmd_sequencer
  import knight_pkg::*;
#(
  parameter int               DEPTH     = 8,
  parameter int               TMO_W     = 24,
  parameter logic [TMO_W-1:0] TMO_LIMIT = 24'd10_000_000,
  parameter int               NRESP_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [15:0]              wr_cmd,
  input  logic [7:0]               wr_exp,
  input  logic [NRESP_W-1:0]       wr_nresp,
  input  logic                     start,
  input  logic                     abort,
  output logic                     send_cmd,
  output logic [15:0]              cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     full,
  output logic                     empty,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   err_idx,
  output logic [$clog2(DEPTH):0]   pass_cnt
);

  localparam int IW = $clog2(DEPTH) + 1;
  localparam int EW = 16 + 8 + NRESP_W;

  seq_state_t         r_state;
  logic               r_send;
  logic [15:0]        r_cmd;
  logic [7:0]         r_exp;
  logic [NRESP_W-1:0] r_rem;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_done;
  logic               r_err;
  err_code_t          r_code;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_pass;

  logic [EW-1:0]      w_head;
  logic [NRESP_W-1:0] w_head_n;
  logic [IW-1:0]      w_count;
  logic               w_has_next;
  logic               w_start_ok;
  logic               w_last_ok;
  logic               w_pop;
  logic               w_tmo_hit;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (wr_en),
    .i_data  ({wr_cmd, wr_exp, wr_nresp}),
    .i_pop   (w_pop),
    .i_flush (abort),
    .o_data  (w_head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (w_count)
  );

  assign w_head_n   = (w_head[NRESP_W-1:0] == '0) ? NRESP_W'(1) : w_head[NRESP_W-1:0];
  assign w_has_next = (w_count != '0);
  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_last_ok  = (r_state == S_WAIT_RESP) && resp_rdy && (resp == r_exp) &&
                      (r_rem == NRESP_W'(1));
  // the head is popped on the edge that enters S_ISSUE so cmd is valid with send_cmd
  assign w_pop      = !abort && w_has_next && (w_start_ok || w_last_ok);
  assign w_tmo_hit  = (r_tmo == TMO_LIMIT - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_send  <= 1'b0;
      r_cmd   <= '0;
      r_exp   <= '0;
      r_rem   <= '0;
      r_tmo   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
      r_idx   <= '0;
      r_pass  <= '0;
    end else begin
      r_send <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              // resuming from ERR keeps the running pass count and failing index
              if (r_state != S_ERR) begin
                r_pass <= '0;
                r_idx  <= '0;
              end
              r_done <= 1'b0;
              r_err  <= 1'b0;
              r_code <= ERR_NONE;
              if (!w_has_next) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            r_state <= S_WAIT_SENT;
            r_tmo   <= '0;
          end
          S_WAIT_SENT: begin
            if (cmd_sent) begin
              r_state <= S_WAIT_RESP;
              r_tmo   <= '0;
            end else if (w_tmo_hit) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_code  <= ERR_SENT_TMO;
              r_idx   <= r_pass;
            end else if (r_tmo != '1) begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          S_WAIT_RESP: begin
            if (resp_rdy) begin
              if (resp != r_exp) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
                r_code  <= ERR_MISMATCH;
                r_idx   <= r_pass;
              end else begin
                r_rem <= r_rem - 1'b1;
                r_tmo <= '0;
                if (r_rem == NRESP_W'(1)) begin
                  r_pass <= r_pass + 1'b1;
                  if (!w_has_next) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                  end
                end
              end
            end else if (w_tmo_hit) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_code  <= ERR_RESP_TMO;
              r_idx   <= r_pass;
            end else if (r_tmo != '1) begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase

        if (w_pop) begin
          r_state <= S_ISSUE;
          r_send  <= 1'b1;
          r_cmd   <= w_head[EW-1 -: 16];
          r_exp   <= w_head[NRESP_W +: 8];
          r_rem   <= w_head_n;
        end
      end
    end
  end

  assign send_cmd = r_send;
  assign cmd      = r_cmd;
  assign busy     = (r_state == S_ISSUE) || (r_state == S_WAIT_SENT) || (r_state == S_WAIT_RESP);
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_code;
  assign err_idx  = r_idx;
  assign pass_cnt = r_pass;

endmodule

// File: tb/tb_knight_cmd_sequencer.sv
// Self-checking bench for knight_cmd_sequencer: a script-level model (entry
// queue, phase, response deadlines) predicts every status output each cycle,
// a responder plays RemoteComm, and literal checks pin the model.
module tb_knight_cmd_sequencer;
  import knight_pkg::*;

  localparam int DEPTH = 8;
  localparam int IW    = $clog2(DEPTH) + 1;
  localparam int LIM   = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_cmd = '0;
  logic [7:0]  wr_exp = '0;
  logic [1:0]  wr_nresp = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        send_cmd;
  logic [15:0] cmd;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        full, empty, busy, done, err;
  logic [1:0]  err_code;
  logic [IW-1:0] err_idx, pass_cnt;

  always #5 clk = ~clk;

  knight_cmd_sequencer #(
    .DEPTH(DEPTH), .TMO_W(24), .TMO_LIMIT(24'd1000), .NRESP_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_exp(wr_exp),
    .wr_nresp(wr_nresp), .start(start), .abort(abort), .send_cmd(send_cmd),
    .cmd(cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .full(full), .empty(empty), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .err_idx(err_idx), .pass_cnt(pass_cnt)
  );

  typedef struct {
    logic [15:0] c;
    logic [7:0]  e;
    int          n;
  } ent_t;

  typedef enum {P_IDLE, P_ISSUE, P_WS, P_WR, P_DONE, P_ERR} ph_t;

  ent_t q[$];
  ent_t cur;
  ph_t  ph;
  int   rem, ev_cyc, dly, cyc, issue_no;
  int   m_send, m_cmd, m_done, m_err, m_code, m_idx, m_pass;
  int   hold_sent, hold_resp, fix_sent, fix_resp, bad_no;
  int   errors = 0, checks = 0, n_sends = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(int f);
    return (f != 0) ? f : int'($urandom_range(1, 40));
  endfunction

  task automatic model_reset();
    q.delete();
    ph = P_IDLE; m_send = 0; m_cmd = 0; m_done = 0; m_err = 0;
    m_code = 0; m_idx = 0; m_pass = 0; rem = 0;
  endtask

  task automatic fail_to(int code);
    ph = P_ERR; m_err = 1; m_code = code; m_idx = m_pass;
  endtask

  // next-cycle outputs from this cycle's inputs
  task automatic model_step();
    bit was_full, go;
    ent_t e;
    was_full = (q.size() == DEPTH);
    go = 0;
    m_send = 0;
    if (abort) begin
      ph = P_IDLE;
      q.delete();
    end else begin
      case (ph)
        P_IDLE, P_DONE, P_ERR: if (start) begin
          if (ph != P_ERR) begin m_pass = 0; m_idx = 0; end
          m_err = 0; m_code = 0; m_done = 0;
          if (q.size() == 0) begin ph = P_DONE; m_done = 1; end
          else go = 1;
        end
        P_ISSUE: begin ph = P_WS; ev_cyc = cyc; dly = pick(fix_sent); end
        P_WS: begin
          if (cmd_sent) begin ph = P_WR; ev_cyc = cyc; dly = pick(fix_resp); end
          else if (cyc == ev_cyc + LIM) fail_to(1);
        end
        P_WR: begin
          if (resp_rdy) begin
            if (resp != cur.e) fail_to(3);
            else begin
              rem--; ev_cyc = cyc; dly = pick(fix_resp);
              if (rem == 0) begin
                m_pass = (m_pass + 1) % (1 << IW);
                if (q.size() == 0) begin ph = P_DONE; m_done = 1; end
                else go = 1;
              end
            end
          end else if (cyc == ev_cyc + LIM) fail_to(2);
        end
        default: ;
      endcase
      if (go) begin
        cur = q.pop_front();
        rem = cur.n; m_send = 1; m_cmd = cur.c; ph = P_ISSUE; issue_no++;
      end
      if (wr_en && !was_full) begin
        e.c = wr_cmd; e.e = wr_exp; e.n = (wr_nresp == 0) ? 1 : int'(wr_nresp);
        q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    cmd_sent = 0; resp_rdy = 0; resp = 8'($urandom);
    if (rst_n) begin
      if (ph == P_WS && hold_sent == 0 && cyc == ev_cyc + dly) cmd_sent = 1;
      if (ph == P_WR && hold_resp == 0 && cyc == ev_cyc + dly) begin
        resp_rdy = 1;
        resp = (issue_no == bad_no) ? ~cur.e : cur.e;
      end
      model_step();
    end else model_reset();
    cyc++;
    @(negedge clk); #1;
    wr_en = 0; start = 0; abort = 0; cmd_sent = 0; resp_rdy = 0;
  endtask

  always @(negedge clk) begin
    chk("send_cmd", 32'(send_cmd), 32'(m_send));
    if (m_send != 0) chk("cmd", 32'(cmd), 32'(m_cmd));
    chk("busy", 32'(busy), 32'(ph == P_ISSUE || ph == P_WS || ph == P_WR));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("err_idx", 32'(err_idx), 32'(m_idx));
    chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    if (send_cmd) n_sends++;
  end

  task automatic push(logic [15:0] c, logic [7:0] e, logic [1:0] n);
    wr_en = 1; wr_cmd = c; wr_exp = e; wr_nresp = n;
    tick();
  endtask

  task automatic run_until(int budget);
    int k = 0;
    do begin tick(); k++; end
    while (!(ph == P_DONE || ph == P_ERR || ph == P_IDLE) && k < budget);
    checks++;
    if (!(ph == P_DONE || ph == P_ERR || ph == P_IDLE)) begin
      errors++;
      $display("FAIL run_until: script still running after %0d cycles", budget);
      abort = 1; tick();
    end
  endtask

  initial begin
    int t, s0, base;
    cyc = 0; issue_no = 0; ev_cyc = 0; dly = 1; bad_no = -1;
    hold_sent = 0; hold_resp = 0; fix_sent = 0; fix_resp = 0;
    model_reset();
    repeat (3) tick();
    chk("reset_empty", 32'(empty), 1);
    chk("reset_cmd", 32'(cmd), 0);
    rst_n = 1;
    tick();

    // start with nothing buffered
    start = 1; tick();
    chk("start_empty_done", 32'(done), 1);

    // calibrate, responses at +100 / +500
    fix_sent = 100; fix_resp = 400;
    push(CMD_CAL, RESP_POS_ACK, 2'd1);
    s0 = n_sends;
    start = 1; tick();
    chk("cal_latency", 32'(send_cmd), 1);
    run_until(1000);
    chk("cal_sends", 32'(n_sends - s0), 1);
    chk("cal_done", 32'(done), 1);
    chk("cal_pass", 32'(pass_cnt), 1);
    fix_sent = 0; fix_resp = 0;

    // four moves
    push({3'b001, 1'b0, NORTH, 4'h1}, RESP_POS_ACK, 2'd1);
    push(16'h23F1, RESP_POS_ACK, 2'd1);
    push(16'h27F1, RESP_POS_ACK, 2'd1);
    push(16'h2BF1, RESP_POS_ACK, 2'd1);
    s0 = n_sends;
    start = 1; tick();
    run_until(2000);
    chk("moves_sends", 32'(n_sends - s0), 4);
    chk("moves_pass", 32'(pass_cnt), 4);
    chk("moves_last_cmd", 32'(cmd), 32'h2BF1);

    // tour command with three responses
    push(16'h4022, RESP_POS_ACK, 2'd3);
    s0 = n_sends;
    start = 1; tick();
    run_until(2000);
    chk("tour_sends", 32'(n_sends - s0), 1);
    chk("tour_pass", 32'(pass_cnt), 1);

    // second entry answered with the wrong byte, then resume
    push(16'h2001, RESP_POS_ACK, 2'd1);
    push(16'h23F1, RESP_POS_ACK, 2'd1);
    push(16'h27F1, RESP_POS_ACK, 2'd1);
    bad_no = issue_no + 2;
    start = 1; tick();
    run_until(2000);
    chk("mm_err", 32'(err), 1);
    chk("mm_code", 32'(err_code), 3);
    chk("mm_idx", 32'(err_idx), 1);
    chk("mm_pass", 32'(pass_cnt), 1);
    start = 1; tick();
    chk("resume_send", 32'(send_cmd), 1);
    chk("resume_cmd", 32'(cmd), 32'h27F1);
    run_until(2000);
    chk("resume_pass", 32'(pass_cnt), 2);
    chk("resume_err", 32'(err), 0);
    bad_no = -1;

    // cmd_sent withheld
    hold_sent = 1;
    push(16'h2001, RESP_POS_ACK, 2'd1);
    start = 1; tick();
    t = 0;
    while (!err && t < 1100) begin tick(); t++; end
    chk("sent_tmo_cycles", 32'(t), LIM + 1);
    chk("sent_tmo_code", 32'(err_code), 1);
    hold_sent = 0;
    abort = 1; tick();
    chk("abort_busy", 32'(busy), 0);

    // response withheld, cmd_sent 10 cycles after send_cmd
    hold_resp = 1; fix_sent = 10;
    push(16'h2001, RESP_POS_ACK, 2'd1);
    start = 1; tick();
    t = 0;
    while (!err && t < 1100) begin tick(); t++; end
    chk("resp_tmo_cycles", 32'(t), 10 + LIM + 1);
    chk("resp_tmo_code", 32'(err_code), 2);
    hold_resp = 0; fix_sent = 0;
    abort = 1; tick();

    // fill, overflow push is dropped
    for (int i = 0; i <= DEPTH; i++) push(16'(16'h2000 + i), RESP_POS_ACK, 2'd1);
    chk("fill_full", 32'(full), 1);
    start = 1; tick();
    run_until(4000);
    chk("fill_pass", 32'(pass_cnt), DEPTH);

    // abort while waiting on the second command's response
    for (int i = 0; i < 4; i++) push(16'(16'h2100 + i), RESP_POS_ACK, 2'd1);
    base = issue_no;
    start = 1; tick();
    t = 0;
    while (!(ph == P_WR && issue_no == base + 2) && t < 500) begin tick(); t++; end
    chk("abort_reach", 32'(t < 500), 1);
    abort = 1; tick();
    chk("abort_busy2", 32'(busy), 0);
    chk("abort_empty", 32'(empty), 1);
    chk("abort_pass", 32'(pass_cnt), 1);

    // randomized scripts, with pushes during execution and occasional bad bytes
    for (int r = 0; r < 8; r++) begin
      int ne = int'($urandom_range(1, 4));
      for (int i = 0; i < ne; i++) push(16'($urandom), 8'($urandom), 2'($urandom));
      bad_no = ($urandom_range(0, 2) == 0) ? issue_no + int'($urandom_range(1, ne)) : -1;
      base = issue_no;
      start = 1; tick();
      t = 0;
      while (!(ph == P_DONE || ph == P_ERR) && t < 3000) begin
        if (issue_no - base < 8 && $urandom_range(0, 5) == 0) begin
          wr_en = 1; wr_cmd = 16'($urandom); wr_exp = 8'($urandom); wr_nresp = 2'($urandom);
        end
        tick(); t++;
      end
      chk("rand_round_end", 32'(ph == P_DONE || ph == P_ERR), 1);
    end
    bad_no = -1;
    abort = 1; tick();

    // async reset mid-run
    for (int i = 0; i < 3; i++) push(16'(16'h2200 + i), RESP_POS_ACK, 2'd1);
    start = 1; tick();
    repeat (30) tick();
    rst_n = 0;
    model_reset();
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_done", 32'(done), 0);
    tick();
    rst_n = 1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/knight_cmd_sequencer.md
Name: knight_cmd_sequencer

Overview:
- Synthesizable command sequencer that drives the RemoteComm command interface for the Knight's Tour system.
- Generalises scripted move/calibrate sequences: buffers up to DEPTH 16-bit commands, each tagged with an expected response byte and a response count.
- Issues the commands in order, waits for each response with per-response timeout, and checks each response byte.
- Sits between a host/script source and RemoteComm (cmd/send_cmd/cmd_sent/resp_rdy/resp). Used for on-chip self-test and as a reusable bench driver.

Parameters:
- DEPTH, 8, command FIFO entries; power of 2, at least 2.
- TMO_W, 24, width of the timeout counter; timeout limit is TMO_LIMIT.
- TMO_LIMIT, 24'd10_000_000, clocks allowed per wait (cmd_sent or each resp_rdy).
- NRESP_W, 2, width of the per-command expected response count (1..3; tour command uses >1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  push one entry into the FIFO
- wr_cmd  in  16  command word, e.g. {3'b001,fanfare,heading[7:0],squares[3:0]}
- wr_exp  in  8  expected response byte, e.g. 8'hA5
- wr_nresp  in  NRESP_W  number of responses to await; 0 is treated as 1
- start  in  1  begin executing the buffered script
- abort  in  1  stop immediately and flush the FIFO
- send_cmd  out  1  one-cycle pulse to RemoteComm
- cmd  out  16  command presented to RemoteComm
- cmd_sent  in  1  RemoteComm transmit-complete pulse
- resp_rdy  in  1  RemoteComm response-valid pulse
- resp  in  8  response byte
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- busy  out  1  high in any state other than IDLE/DONE/ERR
- done  out  1  script completed with no errors; sticky until start or abort
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 cmd_sent timeout, 2 resp timeout, 3 resp mismatch
- err_idx  out  $clog2(DEPTH)+1  index of the failing command
- pass_cnt  out  $clog2(DEPTH)+1  commands completed successfully

Behaviour:
- Reset values: FIFO empty, state IDLE. send_cmd, done, err, err_code, err_idx, pass_cnt, cmd are all 0. busy=0, empty=1, full=0.
- FIFO: circular buffer with wrap-around pointers and a count.
  - wr_en while full is ignored; contents are unchanged.
  - wr_en while busy is accepted when not full, so the script can be appended during execution.
  - A pop and a push in the same cycle keep the count unchanged.
- States:
  - IDLE: start with FIFO non-empty goes to ISSUE and clears done, err, err_code, err_idx and pass_cnt. start with FIFO empty goes directly to DONE with done=1.
  - ISSUE: one cycle. Pop the head; latch cmd, exp and nresp; assert send_cmd for exactly this cycle; clear tmo; go to WAIT_SENT.
  - WAIT_SENT: cmd_sent goes to WAIT_RESP with tmo cleared. tmo==TMO_LIMIT-1 goes to ERR with code 1.
  - WAIT_RESP: on resp_rdy, compare resp to exp.
    - Mismatch goes to ERR with code 3.
    - Match decrements the remaining count and clears tmo. When the count reaches 0: pass_cnt++, then ISSUE if the FIFO is non-empty, else DONE.
    - tmo reaching its limit goes to ERR with code 2.
  - DONE: done=1. start re-arms exactly as from IDLE.
  - ERR: err=1, err_idx = pass_cnt. The remaining FIFO entries are retained. start clears err and resumes at ISSUE with the next entry.
- abort: from any state, next cycle goes to IDLE, flushes the FIFO and clears busy. done, err and pass_cnt are left unchanged. abort beats start in the same cycle.
- A resp_rdy arriving in WAIT_SENT, the same cycle as cmd_sent, is ignored. The bench must not rely on it.
- Latency: send_cmd is asserted 1 clock after start (IDLE→ISSUE registered).
- The timeout counter saturates and never wraps.
- Asynchronous reset mid-operation returns immediately to the reset values.

Decomposition:
- Shared package knight_pkg holds:
  - the state enum seq_state_t;
  - the err_code enum (ERR_NONE, ERR_SENT_TMO, ERR_RESP_TMO, ERR_MISMATCH);
  - constants RESP_POS_ACK=8'hA5, CMD_CAL=16'h0000, and heading bytes NORTH=8'h00, WEST=8'h3F, SOUTH=8'h7F, EAST=8'hBF.
- One sub-module, cmd_fifo (parametrised DEPTH, width 16+8+NRESP_W), exposing full/empty/count.

Test Plan:
- Push CMD_CAL/exp A5/n=1, then start; model returns cmd_sent at +100 and resp=A5 at +500 -> send_cmd pulses once, cmd=16'h0000, done=1, pass_cnt=1, err=0.
- Push 4 moves (north, west, south, east: 16'h2001, 16'h23F1, 16'h27F1, 16'h2BF1) -> four send_cmd pulses in order, done=1, pass_cnt=4.
- Push a tour command 16'h4022 with n=3; model returns A5 three times -> a single send_cmd, done only after the third resp_rdy.
- Second entry's response is 8'h5A -> err=1, err_code=3, err_idx=1, pass_cnt=1. Then start -> resumes with entry 2.
- TMO_LIMIT=1000 and cmd_sent withheld -> err_code=1 at exactly 1000 clocks after send_cmd. Repeat with resp withheld -> err_code=2.
- Fill DEPTH entries, then one extra wr_en -> full=1 and the extra entry is dropped. Assert abort mid-WAIT_RESP -> next cycle IDLE, empty=1, busy=0. Pulse rst_n mid-run -> all outputs at reset values.
